// File: rtl/gray_window_3x3_pkg.sv
// Shared constants, window tap indices and control states for the
// grayscale 3x3 window builder.
package gray_pkg;

   localparam int IMG_W = 640;
   localparam int IMG_H = 480;
   localparam int PIX_W = 12;

   // Row-major tap positions inside the packed window; top row is oldest.
   localparam int WIN_TL = 0;
   localparam int WIN_TC = 1;
   localparam int WIN_TR = 2;
   localparam int WIN_ML = 3;
   localparam int WIN_MC = 4;
   localparam int WIN_MR = 5;
   localparam int WIN_BL = 6;
   localparam int WIN_BC = 7;
   localparam int WIN_BR = 8;

   typedef enum logic [1:0] {
      WAIT_LOW,
      WAIT_HIGH,
      ACTIVE
   } state_e;

endpackage

// File: rtl/gray_window_3x3_line_buffer.sv
// Two cascaded row memories: lb0 holds the previous row, lb1 the row before.
// Registered read port returns the contents from before a same-cycle write.
module gray_line_buffer #(
   parameter int DEPTH = 640,
   parameter int W     = 12,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] addr,
   input  logic [W-1:0]  wr_data,
   output logic [W-1:0]  rd_lb0,
   output logic [W-1:0]  rd_lb1
);

   logic [W-1:0] lb0_mem [DEPTH];
   logic [W-1:0] lb1_mem [DEPTH];
   logic [W-1:0] rd_lb0_q;
   logic [W-1:0] rd_lb1_q;

   // Read old column contents and push the new pixel down the two-row cascade.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         lb0_mem[addr] <= wr_data;
         lb1_mem[addr] <= lb0_mem[addr];
      end
      rd_lb0_q <= lb0_mem[addr];
      rd_lb1_q <= lb1_mem[addr];
   end

   assign rd_lb0 = rd_lb0_q;
   assign rd_lb1 = rd_lb1_q;

endmodule

// File: rtl/gray_window_3x3.sv
// Grayscale row buffers: tracks frame position, keeps the two previous rows
// and emits one interior 3x3 window per accepted pixel, two clocks later.
module gray_window_3x3 #(
   parameter int IMG_W = gray_pkg::IMG_W,
   parameter int IMG_H = gray_pkg::IMG_H,
   parameter int PIX_W = gray_pkg::PIX_W
) (
   input  logic                       iCLK,
   input  logic                       iRST,
   input  logic [PIX_W-1:0]           iGray,
   input  logic                       iDVAL,
   input  logic                       iFVAL,
   output logic [9*PIX_W-1:0]         oWin,
   output logic                       oWVAL,
   output logic [$clog2(IMG_W)-1:0]   oX,
   output logic [$clog2(IMG_H)-1:0]   oY,
   output logic                       oFrameErr
);

   import gray_pkg::*;

   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);
   localparam int RW = $clog2(IMG_H + 1);

   localparam logic [XW-1:0] COL_LAST = XW'(IMG_W - 1);
   localparam logic [XW-1:0] COL_TWO  = XW'(2);
   localparam logic [RW-1:0] ROW_END  = RW'(IMG_H);
   localparam logic [RW-1:0] ROW_TWO  = RW'(2);

   state_e             state_q, state_d;
   logic [XW-1:0]      col_q, col_d;
   logic [RW-1:0]      row_q, row_d;
   logic               err_q, err_d;
   logic               accept, overrun;

   logic               vld_s1_q, vld_s1_d;
   logic [PIX_W-1:0]   pix_s1_q, pix_s1_d;
   logic [XW-1:0]      col_s1_q, col_s1_d;
   logic [RW-1:0]      row_s1_q, row_s1_d;
   logic [PIX_W-1:0]   lb0_rd, lb1_rd;

   logic [9*PIX_W-1:0] win_q, win_d;
   logic [9*PIX_W-1:0] owin_q, owin_d;
   logic               owval_q, owval_d;
   logic [XW-1:0]      ox_q, ox_d;
   logic [YW-1:0]      oy_q, oy_d;

   gray_line_buffer #(
      .DEPTH (IMG_W),
      .W     (PIX_W),
      .AW    (XW)
   ) u_lb (
      .clk     (iCLK),
      .wr_en   (accept),
      .addr    (col_q),
      .wr_data (iGray),
      .rd_lb0  (lb0_rd),
      .rd_lb1  (lb1_rd)
   );

   // Frame state, position counters and frame-length error detection.
   always_comb begin
      accept  = iDVAL & iFVAL & (state_q == ACTIVE) & (row_q <  ROW_END);
      overrun = iDVAL & iFVAL & (state_q == ACTIVE) & (row_q >= ROW_END);
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      err_d   = err_q | overrun;
      case (state_q)
         WAIT_LOW:  if (!iFVAL) state_d = WAIT_HIGH;
         WAIT_HIGH: if (iFVAL) begin
            state_d = ACTIVE;
            col_d   = '0;
            row_d   = '0;
         end
         ACTIVE: begin
            if (!iFVAL) begin
               state_d = WAIT_HIGH;
               if ((row_q != ROW_END) || (col_q != '0)) err_d = 1'b1;
            end else if (accept) begin
               if (col_q == COL_LAST) begin
                  col_d = '0;
                  row_d = row_q + 1'b1;
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         default: state_d = WAIT_LOW;
      endcase
   end

   // Stage 1 aligns the pixel with line-buffer read data; stage 2 shifts the
   // window and publishes it only for interior positions.
   always_comb begin
      vld_s1_d = accept;
      pix_s1_d = iGray;
      col_s1_d = col_q;
      row_s1_d = row_q;
      win_d    = win_q;
      owin_d   = owin_q;
      owval_d  = 1'b0;
      ox_d     = ox_q;
      oy_d     = oy_q;
      if (vld_s1_q) begin
         win_d[WIN_TL*PIX_W +: PIX_W] = win_q[WIN_TC*PIX_W +: PIX_W];
         win_d[WIN_TC*PIX_W +: PIX_W] = win_q[WIN_TR*PIX_W +: PIX_W];
         win_d[WIN_TR*PIX_W +: PIX_W] = lb1_rd;
         win_d[WIN_ML*PIX_W +: PIX_W] = win_q[WIN_MC*PIX_W +: PIX_W];
         win_d[WIN_MC*PIX_W +: PIX_W] = win_q[WIN_MR*PIX_W +: PIX_W];
         win_d[WIN_MR*PIX_W +: PIX_W] = lb0_rd;
         win_d[WIN_BL*PIX_W +: PIX_W] = win_q[WIN_BC*PIX_W +: PIX_W];
         win_d[WIN_BC*PIX_W +: PIX_W] = win_q[WIN_BR*PIX_W +: PIX_W];
         win_d[WIN_BR*PIX_W +: PIX_W] = pix_s1_q;
         if ((row_s1_q >= ROW_TWO) && (col_s1_q >= COL_TWO)) begin
            owval_d = 1'b1;
            owin_d  = win_d;
            ox_d    = col_s1_q - 1'b1;
            oy_d    = YW'(row_s1_q - 1'b1);
         end
      end
   end

   // All control, pipeline and output registers share one synchronous reset.
   always_ff @(posedge iCLK) begin
      if (!iRST) begin
         state_q  <= WAIT_LOW;
         col_q    <= '0;
         row_q    <= '0;
         err_q    <= 1'b0;
         vld_s1_q <= 1'b0;
         pix_s1_q <= '0;
         col_s1_q <= '0;
         row_s1_q <= '0;
         win_q    <= '0;
         owin_q   <= '0;
         owval_q  <= 1'b0;
         ox_q     <= '0;
         oy_q     <= '0;
      end else begin
         state_q  <= state_d;
         col_q    <= col_d;
         row_q    <= row_d;
         err_q    <= err_d;
         vld_s1_q <= vld_s1_d;
         pix_s1_q <= pix_s1_d;
         col_s1_q <= col_s1_d;
         row_s1_q <= row_s1_d;
         win_q    <= win_d;
         owin_q   <= owin_d;
         owval_q  <= owval_d;
         ox_q     <= ox_d;
         oy_q     <= oy_d;
      end
   end

   assign oWin      = owin_q;
   assign oWVAL     = owval_q;
   assign oX        = ox_q;
   assign oY        = oy_q;
   assign oFrameErr = err_q;

endmodule

// File: tb/tb_gray_window_3x3.sv
// Bench for gray_window_3x3 on a reduced 8x4 frame: a frame-array model
// predicts every window, its position and its arrival clock.
module tb_gray_window_3x3;

   localparam int W  = 8;
   localparam int H  = 4;
   localparam int PW = 12;
   localparam int WW = 9 * PW;

   logic          clk = 1'b0;
   logic          iRST, iDVAL, iFVAL;
   logic [PW-1:0] iGray;
   logic [WW-1:0] oWin;
   logic          oWVAL, oFrameErr;
   logic [2:0]    oX;
   logic [1:0]    oY;

   always #5 clk = ~clk;

   gray_window_3x3 #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
      .iCLK(clk), .iRST(iRST), .iGray(iGray), .iDVAL(iDVAL), .iFVAL(iFVAL),
      .oWin(oWin), .oWVAL(oWVAL), .oX(oX), .oY(oY), .oFrameErr(oFrameErr)
   );

   typedef struct { logic [WW-1:0] win; int x; int y; longint due; } exp_t;
   typedef struct { logic [WW-1:0] win; int x; int y; } obs_t;

   int            tests = 0;
   int            fails = 0;
   longint        cyc = 0;
   exp_t          expq[$];
   obs_t          got[$];
   obs_t          t1[$];
   logic [PW-1:0] frame [H][W];
   logic [WW-1:0] last_win = '0;
   int            last_x = 0, last_y = 0;
   bit            fval_low_seen = 0, frame_live = 0, model_err = 0, chk_en = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [WW-1:0] model_win(input int r, input int c);
      logic [WW-1:0] w;
      w = '0;
      for (int dr = 0; dr < 3; dr++)
         for (int dc = 0; dc < 3; dc++)
            w[(dr*3+dc)*PW +: PW] = frame[r-2+dr][c-2+dc];
      return w;
   endfunction

   // Every cycle: a window must appear exactly when the model says, else outputs hold.
   always @(negedge clk) begin
      if (chk_en) begin
         if (oWVAL === 1'b1) begin
            if (expq.size() == 0) begin
               chk("unexpected_window", 128'(oWVAL), 128'(0));
            end else begin
               exp_t e;
               obs_t o;
               e = expq.pop_front();
               chk("win_latency", 128'(cyc), 128'(e.due));
               chk("win_data", 128'(oWin), 128'(e.win));
               chk("win_x", 128'(oX), 128'(e.x));
               chk("win_y", 128'(oY), 128'(e.y));
               o.win = oWin; o.x = int'(oX); o.y = int'(oY);
               got.push_back(o);
               last_win = e.win; last_x = e.x; last_y = e.y;
            end
         end else begin
            if (expq.size() > 0 && expq[0].due <= cyc) begin
               void'(expq.pop_front());
               chk("missing_window", 128'(0), 128'(1));
            end
            chk("hold_win", 128'(oWin), 128'(last_win));
            chk("hold_x", 128'(oX), 128'(last_x));
            chk("hold_y", 128'(oY), 128'(last_y));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      iDVAL = 1'b0;
      repeat (n) tick();
   endtask

   task automatic do_reset();
      exp_t keep[$];
      iDVAL = 1'b0;
      iRST  = 1'b0;
      foreach (expq[i]) if (expq[i].due <= cyc) keep.push_back(expq[i]);
      expq = keep;
      tick();
      chk("rst_wval", 128'(oWVAL), 128'(0));
      chk("rst_win", 128'(oWin), 128'(0));
      chk("rst_x", 128'(oX), 128'(0));
      chk("rst_y", 128'(oY), 128'(0));
      chk("rst_err", 128'(oFrameErr), 128'(0));
      last_win = '0; last_x = 0; last_y = 0;
      model_err = 0; fval_low_seen = 0; frame_live = 0;
      iRST = 1'b1;
   endtask

   function automatic logic [PW-1:0] rand_pix();
      case ($urandom_range(0, 3))
         0: return '0;
         1: return '1;
         default: return PW'($urandom_range(0, 4095));
      endcase
   endfunction

   // gap < 0 means random gaps; stop/reset positions of -1 disable those events.
   task automatic run_frame(input int rows, input int gap, input int stop_r, input int stop_c,
                            input int rst_r, input int rst_c, input bit rnd);
      bit stopped;
      logic [PW-1:0] p;
      exp_t e;
      stopped = 0;
      iFVAL = 1'b0;
      idle(3);
      fval_low_seen = 1;
      iFVAL = 1'b1;
      frame_live = fval_low_seen;
      idle(2);
      for (int r = 0; r < rows && !stopped; r++) begin
         for (int c = 0; c < W && !stopped; c++) begin
            if (r == rst_r && c == rst_c) do_reset();
            p = rnd ? rand_pix() : PW'(16 * r + c);
            iGray = p;
            iDVAL = 1'b1;
            if (frame_live && r < H) begin
               frame[r][c] = p;
               if (r >= 2 && c >= 2) begin
                  e.win = model_win(r, c); e.x = c - 1; e.y = r - 1; e.due = cyc + 2;
                  expq.push_back(e);
               end
            end
            if (frame_live && r >= H) model_err = 1;
            tick();
            iDVAL = 1'b0;
            if (gap < 0) idle($urandom_range(0, 3));
            else idle(gap);
            if (r == stop_r && c == stop_c) stopped = 1;
         end
      end
      iDVAL = 1'b0;
      iFVAL = 1'b0;
      if (frame_live && (stopped || rows != H)) model_err = 1;
      idle(4);
      chk("frame_err", 128'(oFrameErr), 128'(model_err));
   endtask

   initial begin
      int lit[9] = '{0, 1, 2, 16, 17, 18, 32, 33, 34};
      logic [WW-1:0] lit_win;
      iRST = 1'b0; iDVAL = 1'b0; iFVAL = 1'b0; iGray = '0;
      tick(); tick();
      chk("init_wval", 128'(oWVAL), 128'(0));
      chk("init_win", 128'(oWin), 128'(0));
      chk("init_err", 128'(oFrameErr), 128'(0));
      iRST = 1'b1;
      chk_en = 1;

      // Continuous frame with pixel = 16*row + col.
      got.delete();
      run_frame(H, 0, -1, -1, -1, -1, 0);
      lit_win = '0;
      for (int k = 0; k < 9; k++) lit_win[k*PW +: PW] = PW'(lit[k]);
      chk("t1_count", 128'(got.size()), 128'(12));
      if (got.size() == 12) begin
         chk("t1_first_win", 128'(got[0].win), 128'(lit_win));
         chk("t1_first_x", 128'(got[0].x), 128'(1));
         chk("t1_first_y", 128'(got[0].y), 128'(1));
         chk("t1_last_x", 128'(got[11].x), 128'(6));
         chk("t1_last_y", 128'(got[11].y), 128'(2));
      end
      t1 = got;

      // One valid in four: identical window sequence.
      got.delete();
      run_frame(H, 3, -1, -1, -1, -1, 0);
      chk("t2_count", 128'(got.size()), 128'(t1.size()));
      for (int i = 0; i < got.size() && i < t1.size(); i++)
         chk("t2_same_win", 128'(got[i].win), 128'(t1[i].win));

      // Frame cut short after (2,3), then a clean frame; error stays set.
      got.delete();
      run_frame(H, 0, 2, 3, -1, -1, 0);
      chk("t3_count", 128'(got.size()), 128'(2));
      got.delete();
      run_frame(H, 0, -1, -1, -1, -1, 0);
      chk("t3_next_count", 128'(got.size()), 128'(12));
      chk("t3_err_sticky", 128'(oFrameErr), 128'(1));

      // Five rows into a four-row frame.
      got.delete();
      run_frame(H + 1, 0, -1, -1, -1, -1, 0);
      chk("t4_count", 128'(got.size()), 128'(12));

      // Reset mid-frame with frame valid held high, then a clean frame.
      got.delete();
      run_frame(H, 0, -1, -1, 2, 1, 0);
      chk("t5_count", 128'(got.size()), 128'(0));
      got.delete();
      run_frame(H, 1, -1, -1, -1, -1, 0);
      chk("t5_next_count", 128'(got.size()), 128'(12));

      // Random pixels (rich in 0 and full-scale) with random gaps.
      for (int f = 0; f < 20; f++) begin
         got.delete();
         run_frame(H, -1, -1, -1, -1, -1, 1);
         chk("rnd_count", 128'(got.size()), 128'(12));
      end

      idle(5);
      chk("queue_drained", 128'(expq.size()), 128'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
